task_dispatcher: RTL and testbench

TASK_DISPATCHER -- requirements
Module: task_dispatcher

---
 rtl/task_dispatcher.sv | 182 ++++++++++++++++++
 tb/tb_task_dispatcher.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/task_dispatcher.sv
// task_dispatcher: hands out the mu*mu (i,j) block tasks of a blocked matrix
// job to a pool of coprocessors, row-major, lowest-numbered free processor
// first, and signals completion once every block result has been written.
module task_dispatcher #(
   parameter int num_proc    = 2,
   parameter int index_width = 8
) (
   input  logic                   in_clk,
   input  logic                   in_reset,
   input  logic                   in_start,
   input  logic [index_width-1:0] in_mu,
   input  logic [num_proc-1:0]    in_index_ack,
   input  logic [num_proc-1:0]    in_result_ready,
   output logic [index_width-1:0] out_row_index,
   output logic [index_width-1:0] out_col_index,
   output logic [num_proc-1:0]    out_index_ready,
   output logic                   out_busy,
   output logic                   out_done
);

   localparam int cnt_width = 2 * index_width;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ISSUE    = 3'd1,
      ST_WAIT_ACK = 3'd2,
      ST_DRAIN    = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   state_t                 state_r;
   logic [index_width-1:0] mu_r;
   logic [index_width-1:0] row_r;
   logic [index_width-1:0] col_r;
   logic [cnt_width-1:0]   issued_r;
   logic [cnt_width-1:0]   completed_r;
   logic [num_proc-1:0]    proc_busy_r;
   logic [num_proc-1:0]    result_prev_r;
   logic [num_proc-1:0]    target_r;
   logic [num_proc-1:0]    index_ready_r;
   logic                   busy_r;
   logic                   done_r;

   logic [num_proc-1:0]    result_rise_s;
   logic [num_proc-1:0]    complete_s;
   logic [num_proc-1:0]    select_s;
   logic                   select_found_s;
   logic                   ack_hit_s;
   logic                   last_col_s;
   logic [index_width-1:0] mu_last_s;
   logic [cnt_width-1:0]   complete_cnt_s;
   logic [cnt_width-1:0]   completed_next_s;
   logic [cnt_width-1:0]   issued_next_s;
   logic [cnt_width-1:0]   total_s;

   // Result rising edges count only for processors currently holding a task.
   always_comb begin
      result_rise_s  = in_result_ready & ~result_prev_r;
      complete_s     = result_rise_s & proc_busy_r;
      complete_cnt_s = {cnt_width{1'b0}};
      for (int p = 0; p < num_proc; p++) begin
         complete_cnt_s = complete_cnt_s + {{(cnt_width-1){1'b0}}, complete_s[p]};
      end
      completed_next_s = completed_r + complete_cnt_s;
   end

   // One-hot select of the lowest-numbered processor whose busy flag is clear.
   always_comb begin
      select_s       = {num_proc{1'b0}};
      select_found_s = 1'b0;
      for (int p = 0; p < num_proc; p++) begin
         if (!proc_busy_r[p] && !select_found_s) begin
            select_s[p]    = 1'b1;
            select_found_s = 1'b1;
         end else begin
            select_s[p]    = 1'b0;
         end
      end
   end

   // Job bookkeeping: task total, ack match on the target, index wrap point.
   always_comb begin
      total_s       = {{index_width{1'b0}}, mu_r} * {{index_width{1'b0}}, mu_r};
      ack_hit_s     = |(in_index_ack & target_r);
      mu_last_s     = mu_r - {{(index_width-1){1'b0}}, 1'b1};
      last_col_s    = (col_r == mu_last_s);
      issued_next_s = issued_r + {{(cnt_width-1){1'b0}}, 1'b1};
   end

   // Dispatcher FSM and all registered outputs; synchronous active-low reset.
   always_ff @(posedge in_clk) begin
      if (!in_reset) begin
         state_r       <= ST_IDLE;
         mu_r          <= {index_width{1'b0}};
         row_r         <= {index_width{1'b0}};
         col_r         <= {index_width{1'b0}};
         issued_r      <= {cnt_width{1'b0}};
         completed_r   <= {cnt_width{1'b0}};
         proc_busy_r   <= {num_proc{1'b0}};
         result_prev_r <= {num_proc{1'b0}};
         target_r      <= {num_proc{1'b0}};
         index_ready_r <= {num_proc{1'b0}};
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
      end else begin
         result_prev_r <= in_result_ready;
         // busy and done trail the state by one cycle, so busy drops the
         // cycle after the done pulse.
         busy_r        <= (state_r != ST_IDLE);
         done_r        <= (state_r == ST_DONE);
         // Completions free processors in any state; a freed processor is
         // visible to the selector from the following cycle.
         proc_busy_r   <= proc_busy_r & ~complete_s;
         completed_r   <= completed_next_s;
         case (state_r)
            ST_IDLE: begin
               proc_busy_r   <= {num_proc{1'b0}};
               index_ready_r <= {num_proc{1'b0}};
               if (in_start) begin
                  mu_r        <= in_mu;
                  row_r       <= {index_width{1'b0}};
                  col_r       <= {index_width{1'b0}};
                  issued_r    <= {cnt_width{1'b0}};
                  completed_r <= {cnt_width{1'b0}};
                  if (in_mu != {index_width{1'b0}}) begin
                     state_r <= ST_ISSUE;
                  end else begin
                     state_r <= ST_DONE;
                  end
               end
            end
            ST_ISSUE: begin
               if (select_found_s) begin
                  index_ready_r <= select_s;
                  target_r      <= select_s;
                  state_r       <= ST_WAIT_ACK;
               end else begin
                  index_ready_r <= {num_proc{1'b0}};
               end
            end
            ST_WAIT_ACK: begin
               // Index and ready are held until the targeted processor acks;
               // acks from other processors are masked by target_r.
               if (ack_hit_s) begin
                  index_ready_r <= {num_proc{1'b0}};
                  proc_busy_r   <= (proc_busy_r & ~complete_s) | target_r;
                  issued_r      <= issued_next_s;
                  if (last_col_s) begin
                     col_r <= {index_width{1'b0}};
                     row_r <= row_r + {{(index_width-1){1'b0}}, 1'b1};
                  end else begin
                     col_r <= col_r + {{(index_width-1){1'b0}}, 1'b1};
                  end
                  if (issued_next_s == total_s) begin
                     state_r <= ST_DRAIN;
                  end else begin
                     state_r <= ST_ISSUE;
                  end
               end
            end
            ST_DRAIN: begin
               if (completed_next_s == total_s) begin
                  state_r <= ST_DONE;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign out_row_index   = row_r;
   assign out_col_index   = col_r;
   assign out_index_ready = index_ready_r;
   assign out_busy        = busy_r;
   assign out_done        = done_r;

endmodule

// File: tb/tb_task_dispatcher.sv
// Directed bench for task_dispatcher: a per-cycle processor model acks
// indexes and returns results; expected (i,j,processor) tasks are queued at
// job start and checked as each index is acknowledged.
module tb_task_dispatcher;
   localparam int P = 2;
   localparam int W = 8;

   logic         in_clk;
   logic         in_reset;
   logic         in_start;
   logic [W-1:0] in_mu;
   logic [P-1:0] in_index_ack;
   logic [P-1:0] in_result_ready;
   logic [W-1:0] out_row_index;
   logic [W-1:0] out_col_index;
   logic [P-1:0] out_index_ready;
   logic         out_busy;
   logic         out_done;

   typedef struct {
      int i;
      int j;
      int p;
   } task_t;

   task_t        sb[$];
   int           errors;
   int           checks;
   int           ack_delay;
   int           res_delay [P];
   int           res_timer [P];
   int           age [P];
   int           ack_total;
   int           done_count;
   logic [P-1:0] model_busy;
   logic [P-1:0] stray_ack;
   logic [P-1:0] stray_res;
   logic [P-1:0] manual_res;
   logic         auto_res;
   logic         ready_seen;
   logic [P-1:0] prev_ready;
   logic [W-1:0] prev_row;
   logic [W-1:0] prev_col;
   logic         prev_done;
   logic         ack_now;

   task_dispatcher #(.num_proc(P), .index_width(W)) dut (
      .in_clk          (in_clk),
      .in_reset        (in_reset),
      .in_start        (in_start),
      .in_mu           (in_mu),
      .in_index_ack    (in_index_ack),
      .in_result_ready (in_result_ready),
      .out_row_index   (out_row_index),
      .out_col_index   (out_col_index),
      .out_index_ready (out_index_ready),
      .out_busy        (out_busy),
      .out_done        (out_done)
   );

   initial begin
      in_clk = 1'b0;
      forever #5 in_clk = ~in_clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_task(input int i, input int j, input int p);
      task_t e;
      e.i = i;
      e.j = j;
      e.p = p;
      sb.push_back(e);
   endtask

   task automatic reset_model();
      model_busy      = '0;
      stray_ack       = '0;
      stray_res       = '0;
      manual_res      = '0;
      prev_ready      = '0;
      prev_row        = '0;
      prev_col        = '0;
      prev_done       = 1'b0;
      ack_now         = 1'b0;
      in_index_ack    = '0;
      in_result_ready = '0;
      for (int p = 0; p < P; p++) begin
         age[p]       = 0;
         res_timer[p] = 0;
      end
   endtask

   // One clock: sample outputs 1 ns after the edge, check invariants, then
   // run the processor model and drive the next inputs.
   task automatic tick();
      logic [P-1:0] ack_drv;
      logic [P-1:0] res_drv;
      task_t        e;
      @(posedge in_clk);
      #1;
      if (out_index_ready != '0) ready_seen = 1'b1;
      if (in_reset === 1'b1) begin
         chk("ready_onehot0", 32'($onehot0(out_index_ready)), 32'd1);
         chk("ready_to_busy_proc", 32'(out_index_ready & model_busy), 32'd0);
         if (prev_ready != '0 && !ack_now) begin
            chk("hold_ready", 32'(out_index_ready), 32'(prev_ready));
            chk("hold_row", 32'(out_row_index), 32'(prev_row));
            chk("hold_col", 32'(out_col_index), 32'(prev_col));
         end
         if (prev_done) begin
            chk("done_single_pulse", 32'(out_done), 32'd0);
            chk("busy_after_done", 32'(out_busy), 32'd0);
         end
         if (out_done) begin
            done_count++;
            chk("done_after_all_results", 32'(model_busy), 32'd0);
            chk("busy_with_done", 32'(out_busy), 32'd1);
         end
      end
      prev_ready = out_index_ready;
      prev_row   = out_row_index;
      prev_col   = out_col_index;
      prev_done  = out_done;
      ack_drv    = '0;
      res_drv    = '0;
      for (int p = 0; p < P; p++) begin
         if (res_timer[p] > 0) begin
            res_timer[p]--;
            if (res_timer[p] == 0 && auto_res) begin
               res_drv[p]    = 1'b1;
               model_busy[p] = 1'b0;
            end
         end
         if (manual_res[p]) begin
            res_drv[p]    = 1'b1;
            model_busy[p] = 1'b0;
         end
         if (out_index_ready[p] === 1'b1 && in_reset === 1'b1) begin
            age[p]++;
            if (age[p] > ack_delay) begin
               ack_drv[p]    = 1'b1;
               age[p]        = 0;
               model_busy[p] = 1'b1;
               res_timer[p]  = res_delay[p];
               ack_total++;
               chk("sb_pending_at_ack", 32'(sb.size() > 0), 32'd1);
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  chk("task_row", 32'(out_row_index), e.i);
                  chk("task_col", 32'(out_col_index), e.j);
                  chk("task_proc", 32'(out_index_ready), 32'd1 << e.p);
               end
            end
         end else begin
            age[p] = 0;
         end
      end
      ack_now         = |(ack_drv & out_index_ready);
      in_index_ack    = ack_drv | stray_ack;
      in_result_ready = res_drv | stray_res;
      stray_ack       = '0;
      stray_res       = '0;
      manual_res      = '0;
   endtask

   task automatic start_job(input logic [W-1:0] mu);
      done_count = 0;
      ack_total  = 0;
      ready_seen = 1'b0;
      in_mu      = mu;
      in_start   = 1'b1;
      tick();
      in_start   = 1'b0;
   endtask

   task automatic wait_done(input int max);
      int k  = 0;
      int c0 = done_count;
      while (done_count == c0 && k < max) begin
         tick();
         k++;
      end
      chk("wait_done_bound", 32'(done_count != c0), 32'd1);
   endtask

   task automatic wait_acks(input int n, input int max);
      int k = 0;
      while (ack_total < n && k < max) begin
         tick();
         k++;
      end
      chk("wait_ack_bound", 32'(ack_total >= n), 32'd1);
   endtask

   task automatic wait_ready_after(input int n, input int max);
      int k = 0;
      while (!(ack_total >= n && out_index_ready != '0 && !ack_now) && k < max) begin
         tick();
         k++;
      end
      chk("wait_ready_bound", 32'(ack_total >= n && out_index_ready != '0), 32'd1);
   endtask

   task automatic end_job(input string name);
      tick();
      tick();
      chk({name, "_done_count"}, done_count, 32'd1);
      chk({name, "_sb_empty"}, sb.size(), 32'd0);
   endtask

   initial begin
      errors     = 0;
      checks     = 0;
      in_reset   = 1'b0;
      in_start   = 1'b0;
      in_mu      = '0;
      ack_delay  = 1;
      res_delay  = '{5, 5};
      auto_res   = 1'b1;
      ack_total  = 0;
      done_count = 0;
      ready_seen = 1'b0;
      reset_model();

      // Reset state.
      tick();
      tick();
      chk("rst_ready", 32'(out_index_ready), 32'd0);
      chk("rst_busy", 32'(out_busy), 32'd0);
      chk("rst_done", 32'(out_done), 32'd0);
      chk("rst_row", 32'(out_row_index), 32'd0);
      chk("rst_col", 32'(out_col_index), 32'd0);
      in_reset = 1'b1;
      tick();

      // mu=2, ack one cycle after ready, results five cycles after ack.
      push_task(0, 0, 0);
      push_task(0, 1, 1);
      push_task(1, 0, 0);
      push_task(1, 1, 1);
      start_job(8'd2);
      wait_done(300);
      end_job("mu2");
      chk("mu2_task_count", ack_total, 32'd4);

      // mu=0 goes straight to DONE without issuing anything.
      start_job(8'd0);
      chk("mu0_done_first_cycle", 32'(out_done), 32'd0);
      tick();
      chk("mu0_done_second_cycle", 32'(out_done), 32'd1);
      end_job("mu0");
      chk("mu0_no_index_ready", 32'(ready_seen), 32'd0);

      // mu=3 with a slow p0: both busy holds ISSUE, p1 takes every later task.
      res_delay = '{150, 4};
      for (int t = 0; t < 9; t++) begin
         push_task(t / 3, t % 3, (t == 0) ? 0 : 1);
      end
      start_job(8'd3);
      wait_acks(2, 50);
      tick();
      tick();
      chk("both_busy_no_ready", 32'(out_index_ready), 32'd0);
      chk("both_busy_still_busy", 32'(out_busy), 32'd1);
      wait_done(600);
      end_job("mu3");

      // Ack held off 10 cycles; stray ack and stray result on idle p1.
      ack_delay = 10;
      res_delay = '{5, 5};
      push_task(0, 0, 0);
      start_job(8'd1);
      wait_ready_after(0, 20);
      tick();
      tick();
      stray_ack = 2'b10;
      stray_res = 2'b10;
      tick();
      wait_done(100);
      end_job("stray");

      // Reset while waiting for the ack of the third task, then a mu=1 job.
      ack_delay = 4;
      push_task(0, 0, 0);
      push_task(0, 1, 1);
      push_task(1, 0, 0);
      push_task(1, 1, 1);
      start_job(8'd2);
      wait_ready_after(2, 200);
      chk("pre_rst_third_row", 32'(out_row_index), 32'd1);
      in_reset = 1'b0;
      tick();
      chk("midrst_ready", 32'(out_index_ready), 32'd0);
      chk("midrst_busy", 32'(out_busy), 32'd0);
      chk("midrst_done", 32'(out_done), 32'd0);
      chk("midrst_row", 32'(out_row_index), 32'd0);
      chk("midrst_col", 32'(out_col_index), 32'd0);
      chk("midrst_no_done", done_count, 32'd0);
      in_reset = 1'b1;
      reset_model();
      sb.delete();
      ack_delay = 1;
      push_task(0, 0, 0);
      start_job(8'd1);
      wait_done(100);
      end_job("post_rst");
      chk("post_rst_single_task", ack_total, 32'd1);

      // Final two tasks on p0/p1 complete on the same cycle in DRAIN.
      auto_res = 1'b0;
      push_task(0, 0, 0);
      push_task(0, 1, 1);
      push_task(1, 0, 0);
      push_task(1, 1, 1);
      start_job(8'd2);
      wait_acks(2, 50);
      tick();
      tick();
      tick();
      chk("manual_hold_no_ready", 32'(out_index_ready), 32'd0);
      manual_res = 2'b01;
      tick();
      wait_acks(3, 50);
      tick();
      tick();
      tick();
      manual_res = 2'b10;
      tick();
      wait_acks(4, 50);
      tick();
      tick();
      tick();
      tick();
      chk("drain_wait_no_done", 32'(out_done), 32'd0);
      chk("drain_wait_busy", 32'(out_busy), 32'd1);
      manual_res = 2'b11;
      tick();
      tick();
      chk("dual_result_done_pending", 32'(out_done), 32'd0);
      tick();
      chk("dual_result_done", 32'(out_done), 32'd1);
      end_job("dual");
      auto_res = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
